// File: rtl/clock_pkg.sv
// clock_pkg: shared types and constants for the clock codebase.
//   COUNTER_T  seconds since 12:00:00 AM (0..86399)
//   FLAG_T     single-bit flag
//   TIME_T     hour/minute/second field
//   in_state_t command-parser states used by in_m
package clock_pkg;

    typedef logic [16:0] COUNTER_T;
    typedef logic [0:0]  FLAG_T;
    typedef logic [5:0]  TIME_T;

    localparam COUNTER_T COUNTER_MAX   = 17'd86399;
    localparam COUNTER_T MIN_TICK      = 17'd60;
    localparam COUNTER_T HOUR_TICK     = 17'd3600;
    localparam COUNTER_T AMPM_TICK     = 17'd43200;
    localparam TIME_T    HOUR_ROLLOVER = 6'd12;

    localparam logic [7:0] CH_T     = 8'h54;
    localparam logic [7:0] CH_A     = 8'h41;
    localparam logic [7:0] CH_P     = 8'h50;
    localparam logic [7:0] CH_M     = 8'h4D;
    localparam logic [7:0] CH_X     = 8'h58;
    localparam logic [7:0] CH_COLON = 8'h3A;

    typedef enum logic [3:0] {
        ST_IDLE, ST_H1, ST_H0, ST_C1, ST_M1, ST_M0, ST_C2, ST_S1,
        ST_S0, ST_AP, ST_MM, ST_TERM, ST_XTERM, ST_CONV, ST_COMMIT, ST_ERR
    } in_state_t;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= 8'h30) && (b <= 8'h39);
    endfunction

endpackage

// File: rtl/hms_to_counter.sv
// hms_to_counter: combinational (h24, mm, ss) -> seconds since midnight.
//   h24   in  6   hour 0..23
//   mm    in  6   minute 0..59
//   ss    in  6   second 0..59
//   count out 17  h24*3600 + mm*60 + ss
module hms_to_counter
    import clock_pkg::*;
(
    input  logic [5:0]  h24,
    input  logic [5:0]  mm,
    input  logic [5:0]  ss,
    output logic [16:0] count
);

    COUNTER_T h;
    COUNTER_T m;
    COUNTER_T s;

    always_comb begin
        h = {11'b0, h24};
        m = {11'b0, mm};
        s = {11'b0, ss};
        // 3600 = 2048+1024+512+16, 60 = 64-4; the +64 term is added before
        // the -4 term so the running sum never dips below zero
        count = (h << 11) + (h << 10) + (h << 9) + (h << 4)
              + (m << 6) - (m << 2) + s;
    end

endmodule

// File: rtl/in_m.sv
// in_m: ASCII command parser feeding counter_m / alarm_m.
//   "Thh:mm:ssAM\r" sets the clock, "Ahh:mm:ssPM\r" arms the alarm,
//   "X\r" disarms it.  Build macro MIL24_EN selects 24-hour entry
//   ("Thh:mm:ss\r", HH 00..23, no AM/PM suffix).
// Ports:
//   clock, reset          posedge clock, asynchronous active-high reset
//   rx_data/rx_valid/rx_ready  byte stream handshake
//   set_flag, set_time    one-cycle load strobe + value for counter_m
//   alarm_flag, alarm_time alarm armed level + setpoint
//   cmd_err               one-cycle pulse on malformed command
//   busy                  high whenever the parser is not idle
module in_m
    import clock_pkg::*;
#(
    parameter logic [7:0]  TERM_CHAR      = 8'h0D,
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        set_flag,
    output logic [16:0] set_time,
    output logic        alarm_flag,
    output logic [16:0] alarm_time,
    output logic        cmd_err,
    output logic        busy
);

    localparam logic [31:0] TO_LAST = TIMEOUT_CYCLES - 1;

    in_state_t   state;
    in_state_t   nxt;
    FLAG_T       cmd_alarm;
    logic [3:0]  tens;
    TIME_T       hh;
    TIME_T       mm;
    TIME_T       ss;
    TIME_T       h24;
    COUNTER_T    hms_count;
    COUNTER_T    conv_time;
    logic [31:0] idle_cnt;
    logic        accept;
    logic        counting;
    logic        timeout_hit;
    logic        digit_ok;
    logic        byte_ok;
    logic        hh_ok;
    logic        ms_ok;
    logic [6:0]  field_val;
`ifndef MIL24_EN
    logic        pm;
`endif

    assign rx_ready  = !reset && (state != ST_CONV) && (state != ST_COMMIT);
    assign busy      = (state != ST_IDLE);
    assign accept    = rx_valid && rx_ready;
    assign digit_ok  = is_digit(rx_data);
    assign field_val = ({3'b000, tens} * 7'd10) + {3'b000, rx_data[3:0]};
    assign ms_ok     = (field_val <= 7'd59);
`ifdef MIL24_EN
    assign hh_ok     = (field_val <= 7'd23);
`else
    assign hh_ok     = (field_val >= 7'd1) && (field_val <= 7'd12);
`endif

    assign counting    = (state != ST_IDLE) && (state != ST_CONV) && (state != ST_COMMIT);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && counting && !accept && (idle_cnt == TO_LAST);

    always_comb begin
`ifdef MIL24_EN
        h24 = hh;
`else
        h24 = (hh == HOUR_ROLLOVER) ? '0 : hh;
        if (pm) h24 = h24 + HOUR_ROLLOVER;
`endif
    end

    hms_to_counter u_hms (
        .h24   (h24),
        .mm    (mm),
        .ss    (ss),
        .count (hms_count)
    );

    // Byte legality and successor for the current field state.
    always_comb begin
        byte_ok = 1'b0;
        nxt     = state;
        case (state)
            ST_IDLE: begin
                byte_ok = (rx_data inside {CH_T, CH_A, CH_X}) || (rx_data == TERM_CHAR);
                if (rx_data == CH_X)           nxt = ST_XTERM;
                else if (rx_data == TERM_CHAR) nxt = ST_IDLE;
                else                           nxt = ST_H1;
            end
            ST_H1:    begin byte_ok = digit_ok;           nxt = ST_H0;   end
            ST_H0:    begin byte_ok = digit_ok && hh_ok;  nxt = ST_C1;   end
            ST_C1:    begin byte_ok = (rx_data == CH_COLON); nxt = ST_M1; end
            ST_M1:    begin byte_ok = digit_ok;           nxt = ST_M0;   end
            ST_M0:    begin byte_ok = digit_ok && ms_ok;  nxt = ST_C2;   end
            ST_C2:    begin byte_ok = (rx_data == CH_COLON); nxt = ST_S1; end
            ST_S1:    begin byte_ok = digit_ok;           nxt = ST_S0;   end
            ST_S0: begin
                byte_ok = digit_ok && ms_ok;
`ifdef MIL24_EN
                nxt = ST_TERM;
`else
                nxt = ST_AP;
`endif
            end
            ST_AP:    begin byte_ok = (rx_data == CH_A) || (rx_data == CH_P); nxt = ST_MM; end
            ST_MM:    begin byte_ok = (rx_data == CH_M);      nxt = ST_TERM; end
            ST_TERM:  begin byte_ok = (rx_data == TERM_CHAR); nxt = ST_CONV; end
            ST_XTERM: begin byte_ok = (rx_data == TERM_CHAR); nxt = ST_IDLE; end
            ST_ERR: begin
                byte_ok = 1'b1;
                nxt     = (rx_data == TERM_CHAR) ? ST_IDLE : ST_ERR;
            end
            default:  begin byte_ok = 1'b1; nxt = state; end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            cmd_alarm  <= '0;
            tens       <= '0;
            hh         <= '0;
            mm         <= '0;
            ss         <= '0;
            conv_time  <= '0;
            idle_cnt   <= '0;
            set_flag   <= 1'b0;
            set_time   <= '0;
            alarm_flag <= 1'b0;
            alarm_time <= '0;
            cmd_err    <= 1'b0;
`ifndef MIL24_EN
            pm         <= 1'b0;
`endif
        end else begin
            set_flag <= 1'b0;
            cmd_err  <= 1'b0;

            if (accept || !counting || timeout_hit) idle_cnt <= '0;
            else                                    idle_cnt <= idle_cnt + 32'd1;

            if (timeout_hit) begin
                state <= ST_IDLE;
            end else if (state == ST_CONV) begin
                conv_time <= hms_count;
                state     <= ST_COMMIT;
            end else if (state == ST_COMMIT) begin
                if (cmd_alarm == 1'b1) begin
                    alarm_time <= conv_time;
                    alarm_flag <= 1'b1;
                end else begin
                    set_time <= conv_time;
                    set_flag <= 1'b1;
                end
                state <= ST_IDLE;
            end else if (accept) begin
                if (byte_ok) begin
                    state <= nxt;
                    case (state)
                        ST_IDLE:             cmd_alarm <= FLAG_T'(rx_data == CH_A);
                        ST_H1, ST_M1, ST_S1: tens <= rx_data[3:0];
                        ST_H0:               hh <= field_val[5:0];
                        ST_M0:               mm <= field_val[5:0];
                        ST_S0:               ss <= field_val[5:0];
`ifndef MIL24_EN
                        ST_AP:               pm <= (rx_data == CH_P);
`endif
                        ST_XTERM:            alarm_flag <= 1'b0;
                        default: ;
                    endcase
                end else begin
                    cmd_err <= 1'b1;
                    // a stray terminator already ends the command, so there is
                    // nothing left to discard
                    state <= (rx_data == TERM_CHAR) ? ST_IDLE : ST_ERR;
                end
            end
        end
    end

endmodule

// File: tb/tb_in_m.sv
// tb_in_m: randomized + directed bench for in_m with a scoreboard.
// Ports of in_m are all connected; MIL24_EN selects the 24-hour model.
module tb_in_m;

    localparam int unsigned TO = 1000;
    localparam logic [7:0]  CR = 8'h0D;

    localparam int K_NONE = 0, K_SET = 1, K_ALARM = 2, K_DISARM = 3, K_ERR = 4;
    localparam int EV_SET = 1, EV_ALARM = 2, EV_ERR = 3;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        set_flag;
    logic [16:0] set_time;
    logic        alarm_flag;
    logic [16:0] alarm_time;
    logic        cmd_err;
    logic        busy;

    in_m #(.TERM_CHAR(CR), .TIMEOUT_CYCLES(TO)) dut (
        .clock      (clock),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .set_flag   (set_flag),
        .set_time   (set_time),
        .alarm_flag (alarm_flag),
        .alarm_time (alarm_time),
        .cmd_err    (cmd_err),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    typedef struct { int kind; int val; int cyc; } exp_t;
    exp_t sbq[$];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int m_set = 0, m_af = 0, m_at = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input int val, input int at);
        exp_t e;
        e.kind = kind; e.val = val; e.cyc = at;
        sbq.push_back(e);
    endtask

    task automatic pop_check(input int kind, input int val);
        exp_t e;
        if (sbq.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_event: got kind %0d value %0d at cycle %0d, expected none",
                     kind, val, cyc);
        end else begin
            e = sbq.pop_front();
            check("event_kind", kind, e.kind);
            check("event_value", val, e.val);
            check("event_cycle", cyc, e.cyc);
        end
    endtask

    // Monitor: every observable output event must match the queue head.
    logic        prev_af;
    logic [16:0] prev_at;
    logic        sf_prev;
    always @(negedge clock) begin
        if (reset) begin
            prev_af = alarm_flag;
            prev_at = alarm_time;
            sf_prev = 1'b0;
        end else begin
            if (set_flag) begin
                if (sf_prev) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL set_flag_width: got high for 2+ cycles, expected 1");
                end
                pop_check(EV_SET, int'(set_time));
            end
            sf_prev = set_flag;
            if (cmd_err) pop_check(EV_ERR, 0);
            if (alarm_flag != prev_af || alarm_time != prev_at) begin
                pop_check(EV_ALARM, int'({alarm_flag, alarm_time}));
                prev_af = alarm_flag;
                prev_at = alarm_time;
            end
        end
    end

    function automatic bit isd(input logic [7:0] c);
        return (c >= 8'h30) && (c <= 8'h39);
    endfunction

    function automatic int dv(input logic [7:0] c);
        return int'(c) - 48;
    endfunction

    // Reference: checks the string against the command grammar and reports the
    // outcome plus the index of the byte whose acceptance produces it.
    function automatic void model_cmd(input string s, output int kind, output int val,
                                      output int evidx);
        int n, hh, mm, ss, h24;
        bit pm, ok;
        logic [7:0] c;
        kind = K_NONE; val = 0; evidx = -1;
        hh = 0; mm = 0; ss = 0; pm = 1'b0;
        if (s.len() == 0) return;
        c = s[0];
        if (c == "X") begin
            if (s.len() < 2) return;
            evidx = 1;
            kind = (s[1] == CR) ? K_DISARM : K_ERR;
            return;
        end
        if (c != "T" && c != "A") begin
            kind = K_ERR; evidx = 0;
            return;
        end
`ifdef MIL24_EN
        n = 10;
`else
        n = 12;
`endif
        for (int i = 1; i < n; i++) begin
            if (i >= s.len()) return;
            c = s[i];
            ok = 1'b0;
            case (i)
                1, 4, 7: ok = isd(c);
                2: begin
                    hh = dv(s[1]) * 10 + dv(c);
`ifdef MIL24_EN
                    ok = isd(c) && hh <= 23;
`else
                    ok = isd(c) && hh >= 1 && hh <= 12;
`endif
                end
                5: begin mm = dv(s[4]) * 10 + dv(c); ok = isd(c) && mm <= 59; end
                8: begin ss = dv(s[7]) * 10 + dv(c); ok = isd(c) && ss <= 59; end
                3, 6: ok = (c == ":");
`ifdef MIL24_EN
                9: ok = (c == CR);
`else
                9: begin ok = (c == "A") || (c == "P"); pm = (c == "P"); end
                10: ok = (c == "M");
                11: ok = (c == CR);
`endif
                default: ok = 1'b0;
            endcase
            if (!ok) begin
                kind = K_ERR; evidx = i;
                return;
            end
        end
`ifdef MIL24_EN
        h24 = hh;
`else
        h24 = (hh % 12) + (pm ? 12 : 0);
`endif
        val = h24 * 3600 + mm * 60 + ss;
        kind = (s[0] == "T") ? K_SET : K_ALARM;
        evidx = n - 1;
    endfunction

    function automatic string cmd(input string body);
        return $sformatf("%s%c", body, CR);
    endfunction

    // Drive one command byte by byte; queue the predicted event when the
    // triggering byte is accepted.
    task automatic send_cmd(input string s);
        int kind, val, evidx, k, tries;
        bit rdy;
        model_cmd(s, kind, val, evidx);
        for (int i = 0; i < s.len(); i++) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
            rx_data  = s[i];
            rx_valid = 1'b1;
            tries = 0;
            k = 0;
            do begin
                @(negedge clock);
                rdy = rx_ready;
                k = cyc;
                @(posedge clock);
                tries++;
            end while (!rdy && tries < 50);
            #1;
            rx_valid = 1'b0;
            if (!rdy) begin
                check("rx_ready_timeout", 0, 1);
                return;
            end
            if (i == evidx) begin
                case (kind)
                    K_SET: begin push(EV_SET, val, k + 3); m_set = val; end
                    K_ALARM: begin
                        if (!(m_af == 1 && m_at == val)) push(EV_ALARM, (1 << 17) | val, k + 3);
                        m_af = 1; m_at = val;
                    end
                    K_DISARM: begin
                        if (m_af == 1) push(EV_ALARM, m_at, k + 1);
                        m_af = 0;
                    end
                    K_ERR: push(EV_ERR, 0, k + 1);
                    default: ;
                endcase
            end
        end
    endtask

    task automatic settle();
        for (int w = 0; w < 12 && sbq.size() != 0; w++) @(posedge clock);
        repeat (3) @(posedge clock);
        #1;
        check("queue_drained", sbq.size(), 0);
        check("set_time_hold", int'(set_time), m_set);
        check("alarm_flag", int'(alarm_flag), m_af);
        check("alarm_time", int'(alarm_time), m_at);
        check("busy_idle", int'(busy), 0);
    endtask

    task automatic run(input string s);
        send_cmd(s);
        settle();
    endtask

    task automatic random_cmd();
        int r, hh, mm, ss, pos;
        logic [7:0] cc, b;
        string s;
        r = $urandom_range(0, 99);
`ifdef MIL24_EN
        hh = $urandom_range(0, 23);
        if (r < 12) hh = $urandom_range(24, 99);
`else
        hh = $urandom_range(1, 12);
        if (r < 12) hh = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(13, 99);
`endif
        mm = $urandom_range(0, 59);
        ss = $urandom_range(0, 59);
        if (r >= 12 && r < 18) mm = $urandom_range(60, 99);
        if (r >= 18 && r < 24) ss = $urandom_range(60, 99);
        cc = ($urandom_range(0, 1) == 0) ? "T" : "A";
        s = $sformatf("%c%02d:%02d:%02d", cc, hh, mm, ss);
`ifndef MIL24_EN
        s = {s, ($urandom_range(0, 1) == 0) ? "AM" : "PM"};
`endif
        s = cmd(s);
        if (r >= 70 && r < 86) begin
            pos = $urandom_range(0, s.len() - 2);
            b = 8'($urandom_range(1, 255));
            if (b == CR) b = 8'h5A;
            s.putc(pos, b);
        end
        if (r >= 86) s = cmd("X");
        run(s);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clock);
        #1;
        check("reset_rx_ready", int'(rx_ready), 0);
        check("reset_outputs", int'({set_flag, set_time, alarm_flag, alarm_time, cmd_err, busy}), 0);
        reset = 1'b0;
        @(posedge clock); #1;
        check("idle_rx_ready", int'(rx_ready), 1);

        // basic set and alarm arm/disarm
        run(cmd("T09:42:33AM"));
`ifndef MIL24_EN
        check("t1_set_time", int'(set_time), 34953);
        check("t1_alarm_off", int'(alarm_flag), 0);
`endif
        run(cmd("A02:08:45PM"));
`ifndef MIL24_EN
        check("t2_alarm_flag", int'(alarm_flag), 1);
        check("t2_alarm_time", int'(alarm_time), 50925);
`endif
        run(cmd("X"));
        check("t2_disarm", int'(alarm_flag), 0);
`ifndef MIL24_EN
        check("t2_alarm_hold", int'(alarm_time), 50925);
`endif

        // boundaries
        run(cmd("T12:00:00AM"));
`ifndef MIL24_EN
        check("t3_midnight", int'(set_time), 0);
`endif
        run(cmd("T12:00:00PM"));
`ifndef MIL24_EN
        check("t3_noon", int'(set_time), 43200);
`endif
        run(cmd("T11:59:59PM"));
`ifndef MIL24_EN
        check("t3_last", int'(set_time), 86399);
`endif

        // malformed commands followed by a good one
        run(cmd("T13:00:00AM"));
        run(cmd("T09:60:00AM"));
        run(cmd("Q"));
        run(cmd("T09:42:33AM"));

        // 24-hour entry
        run(cmd("T23:59:59"));
`ifdef MIL24_EN
        check("t6_mil24", int'(set_time), 86399);
`endif

        // arm, then reset mid-command
        run(cmd("A01:00:00PM"));
        send_cmd("T09:4");
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("midcmd_reset_outputs",
              int'({set_flag, set_time, alarm_flag, alarm_time, cmd_err, busy, rx_ready}), 0);
        m_set = 0; m_af = 0; m_at = 0;
        sbq.delete();
        reset = 1'b0;
        @(posedge clock); #1;
        check("post_reset_rx_ready", int'(rx_ready), 1);
        run(cmd("T09:42:33AM"));
`ifndef MIL24_EN
        check("t5_after_reset", int'(set_time), 34953);
`endif

        // silent timeout
        send_cmd("T09:4");
        repeat (995) @(negedge clock);
        check("timeout_still_busy", int'(busy), 1);
        repeat (10) @(negedge clock);
        check("timeout_idle", int'(busy), 0);
        settle();
        run(cmd("A02:08:45PM"));

        for (int n = 0; n < 80; n++) random_cmd();

        check("final_queue_empty", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
